cc_assoc_array: RTL and testbench

//  Parametrised N-way set-associative code-cache array: tag, valid, NRU and line

---
 rtl/cc_assoc_array_if.sv | 37 +++
 rtl/cc_assoc_array.sv | 189 ++++++++++++++++++
 tb/tb_cc_assoc_array.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cc_assoc_array_if.sv
// Request/response bundle between the fetch/L2-fill side and the code-cache array.
// fill_en is held by the master until the one-cycle fill_ack; rd_en and inv_en are single-cycle.
interface cc_assoc_array_if #(
    parameter int WAYS      = 8,
    parameter int SET_BITS  = 7,
    parameter int ADDR_BITS = 37,
    parameter int LINE_BITS = 1040
) ();
    logic                 rd_en;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 rd_hit;
    logic [WAYS-1:0]      rd_way;
    logic [LINE_BITS-1:0] rd_data;
    logic                 rd_err;
    logic                 fill_en;
    logic [ADDR_BITS-1:0] fill_addr;
    logic [LINE_BITS-1:0] fill_data;
    logic                 fill_ack;
    logic                 expun_vld;
    logic [ADDR_BITS-1:0] expun_addr;
    logic                 inv_en;
    logic [ADDR_BITS-1:0] inv_addr;
    logic                 init_busy;
    logic                 dbg_state;

    modport master (
        output rd_en, rd_addr, fill_en, fill_addr, fill_data, inv_en, inv_addr,
        input  rd_hit, rd_way, rd_data, rd_err, fill_ack, expun_vld, expun_addr,
               init_busy, dbg_state
    );

    modport slave (
        input  rd_en, rd_addr, fill_en, fill_addr, fill_data, inv_en, inv_addr,
        output rd_hit, rd_way, rd_data, rd_err, fill_ack, expun_vld, expun_addr,
               init_busy, dbg_state
    );
endinterface

// File: rtl/cc_assoc_array.sv
// N-way set-associative code-cache array: tag/valid/NRU/data storage with init sweep,
// fill with victim eviction report, invalidate and fill-to-read bypass. Falling-edge clocked.
module cc_assoc_array #(
    parameter int WAYS      = 8,
    parameter int SET_BITS  = 7,
    parameter int ADDR_BITS = 37,
    parameter int LINE_BITS = 1040
) (
    input logic              clk,
    input logic              rst,
    cc_assoc_array_if.slave  bus
);
    localparam int SETS     = 1 << SET_BITS;
    localparam int TAG_BITS = ADDR_BITS - SET_BITS;
    localparam int WAY_IDX  = $clog2(WAYS);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               state;
    logic [SET_BITS-1:0]  init_cnt;
    logic [TAG_BITS-1:0]  tag_mem  [SETS][WAYS];
    logic [LINE_BITS-1:0] data_mem [SETS][WAYS];
    logic [WAYS-1:0]      valid_q  [SETS];
    logic [WAYS-1:0]      used_q   [SETS];

    logic                 rd_hit_q, rd_err_q, fill_ack_q, expun_vld_q, init_busy_q;
    logic [WAYS-1:0]      rd_way_q;
    logic [LINE_BITS-1:0] rd_data_q;
    logic [ADDR_BITS-1:0] expun_addr_q;

    function automatic logic [WAYS-1:0] lowest_oh(input logic [WAYS-1:0] v);
        logic [WAYS-1:0] r;
        r = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [WAY_IDX-1:0] oh_idx(input logic [WAYS-1:0] oh);
        logic [WAY_IDX-1:0] r;
        r = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (oh[i]) r = WAY_IDX'(i);
        end
        return r;
    endfunction

    // Mark a way used; a saturated set keeps only the way just touched.
    function automatic logic [WAYS-1:0] nru_touch(input logic [WAYS-1:0] u, input logic [WAYS-1:0] oh);
        logic [WAYS-1:0] t;
        t = u | oh;
        if (&t) t = oh;
        return t;
    endfunction

    wire [SET_BITS-1:0] rd_set   = bus.rd_addr[SET_BITS-1:0];
    wire [TAG_BITS-1:0] rd_tag   = bus.rd_addr[ADDR_BITS-1:SET_BITS];
    wire [SET_BITS-1:0] fill_set = bus.fill_addr[SET_BITS-1:0];
    wire [TAG_BITS-1:0] fill_tag = bus.fill_addr[ADDR_BITS-1:SET_BITS];
    wire [SET_BITS-1:0] inv_set  = bus.inv_addr[SET_BITS-1:0];
    wire [TAG_BITS-1:0] inv_tag  = bus.inv_addr[ADDR_BITS-1:SET_BITS];

    logic [WAYS-1:0] rd_match, fill_match, inv_match;
    always_comb begin
        rd_match   = '0;
        fill_match = '0;
        inv_match  = '0;
        for (int w = 0; w < WAYS; w++) begin
            rd_match[w]   = valid_q[rd_set][w]   && (tag_mem[rd_set][w]   == rd_tag);
            fill_match[w] = valid_q[fill_set][w] && (tag_mem[fill_set][w] == fill_tag);
            inv_match[w]  = valid_q[inv_set][w]  && (tag_mem[inv_set][w]  == inv_tag);
        end
    end

    // fill_ack_q blocks re-acceptance while the master still holds fill_en after its ack.
    wire running   = (state == ST_RUN);
    wire fill_acc  = bus.fill_en && running && !bus.inv_en && !fill_ack_q;
    wire inv_acc   = bus.inv_en && running;
    wire rd_acc    = bus.rd_en && running;
    wire rd_bypass = rd_acc && fill_acc && (bus.rd_addr == bus.fill_addr);

    wire [WAYS-1:0]    rd_hit_oh = lowest_oh(rd_match);
    wire               rd_upd    = rd_acc && !rd_bypass && (rd_match != '0);
    wire [WAY_IDX-1:0] rd_idx    = oh_idx(rd_hit_oh);

    logic [WAYS-1:0] victim_oh;
    logic            evict;
    always_comb begin
        victim_oh = lowest_oh(fill_match);
        evict     = 1'b0;
        if (fill_match == '0) begin
            if (~valid_q[fill_set] != '0) begin
                victim_oh = lowest_oh(~valid_q[fill_set]);
            end else begin
                evict     = 1'b1;
                victim_oh = (~used_q[fill_set] != '0) ? lowest_oh(~used_q[fill_set]) : WAYS'(1);
            end
        end
    end
    wire [WAY_IDX-1:0] victim_idx = oh_idx(victim_oh);

    // Same-set updates chain so a concurrent read hit is not lost behind a fill/invalidate.
    wire [WAYS-1:0] used_rd = nru_touch(used_q[rd_set], rd_hit_oh);
    wire [WAYS-1:0] used_f  = nru_touch((rd_upd && rd_set == fill_set) ? used_rd : used_q[fill_set], victim_oh);
    wire [WAYS-1:0] used_i  = ((rd_upd && rd_set == inv_set) ? used_rd : used_q[inv_set]) & ~inv_match;

    always_ff @(negedge clk) begin
        if (!rst && fill_acc) begin
            tag_mem[fill_set][victim_idx]  <= fill_tag;
            data_mem[fill_set][victim_idx] <= bus.fill_data;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state        <= ST_INIT;
            init_cnt     <= '0;
            init_busy_q  <= 1'b1;
            rd_hit_q     <= 1'b0;
            rd_way_q     <= '0;
            rd_data_q    <= '0;
            rd_err_q     <= 1'b0;
            fill_ack_q   <= 1'b0;
            expun_vld_q  <= 1'b0;
            expun_addr_q <= '0;
        end else begin
            fill_ack_q  <= fill_acc;
            expun_vld_q <= fill_acc && evict;
            if (fill_acc && evict) expun_addr_q <= {tag_mem[fill_set][victim_idx], fill_set};

            case (state)
                ST_INIT: begin
                    valid_q[init_cnt] <= '0;
                    used_q[init_cnt]  <= '0;
                    init_cnt          <= init_cnt + 1'b1;
                    if (init_cnt == SET_BITS'(SETS - 1)) begin
                        state       <= ST_RUN;
                        init_busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rd_upd) used_q[rd_set] <= used_rd;
                    if (fill_acc) begin
                        valid_q[fill_set] <= valid_q[fill_set] | victim_oh;
                        used_q[fill_set]  <= used_f;
                    end
                    if (inv_acc) begin
                        valid_q[inv_set] <= valid_q[inv_set] & ~inv_match;
                        used_q[inv_set]  <= used_i;
                    end
                end
                default: state <= ST_INIT;
            endcase

            if (bus.rd_en) begin
                if (rd_bypass) begin
                    rd_hit_q  <= 1'b1;
                    rd_way_q  <= victim_oh;
                    rd_data_q <= bus.fill_data;
                    rd_err_q  <= 1'b0;
                end else if (rd_acc) begin
                    rd_hit_q  <= (rd_match != '0);
                    rd_way_q  <= rd_hit_oh;
                    rd_data_q <= (rd_match != '0) ? data_mem[rd_set][rd_idx] : '0;
                    rd_err_q  <= ((rd_match & ~rd_hit_oh) != '0);
                end else begin
                    rd_hit_q  <= 1'b0;
                    rd_way_q  <= '0;
                    rd_data_q <= '0;
                    rd_err_q  <= 1'b0;
                end
            end
        end
    end

    assign bus.rd_hit     = rd_hit_q;
    assign bus.rd_way     = rd_way_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.fill_ack   = fill_ack_q;
    assign bus.expun_vld  = expun_vld_q;
    assign bus.expun_addr = expun_addr_q;
    assign bus.init_busy  = init_busy_q;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_cc_assoc_array.sv
// Directed scoreboard bench for cc_assoc_array: init sweep, hit/miss, NRU eviction,
// invalidate priority, fill-to-read bypass and mid-sweep reset.
module tb_cc_assoc_array;
    localparam int WAYS      = 8;
    localparam int SET_BITS  = 7;
    localparam int ADDR_BITS = 37;
    localparam int LINE_BITS = 1040;
    localparam int EW        = 2 + WAYS + LINE_BITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cc_assoc_array_if #(.WAYS(WAYS), .SET_BITS(SET_BITS), .ADDR_BITS(ADDR_BITS), .LINE_BITS(LINE_BITS)) bus ();
    cc_assoc_array #(.WAYS(WAYS), .SET_BITS(SET_BITS), .ADDR_BITS(ADDR_BITS), .LINE_BITS(LINE_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [EW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ADDR_BITS-1:0] la(input int tag, input int set);
        return (ADDR_BITS'(tag) << SET_BITS) | ADDR_BITS'(set);
    endfunction

    function automatic logic [LINE_BITS-1:0] rand_line();
        logic [LINE_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < (LINE_BITS + 31) / 32; i++) r = {r[LINE_BITS-33:0], $urandom()};
        return r;
    endfunction

    task automatic check_read();
        logic [EW-1:0]        e;
        logic [LINE_BITS-1:0] g, x;
        chk("rd_q_len", 128'(exp_q.size()), 128'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("rd_err", 128'(bus.rd_err), 128'(e[EW-1]));
        chk("rd_hit", 128'(bus.rd_hit), 128'(e[EW-2]));
        chk("rd_way", 128'(bus.rd_way), 128'(e[LINE_BITS +: WAYS]));
        for (int i = 0; i < (LINE_BITS + 127) / 128; i++) begin
            g = bus.rd_data >> (i * 128);
            x = e[LINE_BITS-1:0] >> (i * 128);
            chk($sformatf("rd_data_%0d", i), g[127:0], x[127:0]);
        end
    endtask

    // One clock: DUT updates on the falling edge, outputs are sampled on the rising edge.
    task automatic tick();
        @(posedge clk);
        if (bus.rd_en) check_read();
        bus.rd_en  = 1'b0;
        bus.inv_en = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_BITS-1:0] a, input logic hit, input logic [WAYS-1:0] way,
                      input logic [LINE_BITS-1:0] d);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        exp_q.push_back({1'b0, hit, way, d});
        tick();
    endtask

    task automatic fill(input logic [ADDR_BITS-1:0] a, input logic [LINE_BITS-1:0] d, input logic ev,
                        input logic [ADDR_BITS-1:0] ea, output int lat);
        lat           = 0;
        bus.fill_en   = 1'b1;
        bus.fill_addr = a;
        bus.fill_data = d;
        do begin
            tick();
            lat++;
        end while (!bus.fill_ack && lat < 20);
        bus.fill_en = 1'b0;
        chk("fill_ack", 128'(bus.fill_ack), 128'd1);
        chk("expun_vld", 128'(bus.expun_vld), 128'(ev));
        if (ev) chk("expun_addr", 128'(bus.expun_addr), 128'(ea));
    endtask

    task automatic count_busy(output int c);
        c = 0;
        while (bus.init_busy && c < 300) begin
            c++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cnt;
        logic [LINE_BITS-1:0] line_a, d5[1:9], d6[1:10], dn, x7, y7, z;

        rst           = 1'b1;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.fill_en   = 1'b0;
        bus.fill_addr = '0;
        bus.fill_data = '0;
        bus.inv_en    = 1'b0;
        bus.inv_addr  = '0;

        // T1: reset values and init sweep length
        tick();
        tick();
        chk("rst_rd_hit", 128'(bus.rd_hit), 128'd0);
        chk("rst_rd_way", 128'(bus.rd_way), 128'd0);
        chk("rst_rd_data", 128'(|bus.rd_data), 128'd0);
        chk("rst_rd_err", 128'(bus.rd_err), 128'd0);
        chk("rst_fill_ack", 128'(bus.fill_ack), 128'd0);
        chk("rst_expun_vld", 128'(bus.expun_vld), 128'd0);
        chk("rst_expun_addr", 128'(bus.expun_addr), 128'd0);
        chk("rst_init_busy", 128'(bus.init_busy), 128'd1);
        chk("rst_state", 128'(bus.dbg_state), 128'd0);
        rst = 1'b0;
        count_busy(cnt);
        chk("init_busy_cycles", 128'(cnt), 128'd128);
        chk("run_state", 128'(bus.dbg_state), 128'd1);
        rd(la(3, 17), 1'b0, '0, '0);
        rd(la(85, 0), 1'b0, '0, '0);

        // T2: single fill then hit / neighbour miss
        line_a = rand_line();
        fill(37'h0000123, line_a, 1'b0, '0, lat);
        chk("fill_latency", 128'(lat), 128'd1);
        rd(37'h0000123, 1'b1, 8'h01, line_a);
        rd(37'h0000124, 1'b0, '0, '0);

        // T3: nine tags into set 5 evict way 0; rewrite in place; evicted line misses
        for (int t = 1; t <= 9; t++) d5[t] = rand_line();
        for (int t = 1; t <= 8; t++) fill(la(t, 5), d5[t], 1'b0, '0, lat);
        fill(la(9, 5), d5[9], 1'b1, la(1, 5), lat);
        tick();
        chk("expun_one_cycle", 128'(bus.expun_vld), 128'd0);
        dn = rand_line();
        fill(la(5, 5), dn, 1'b0, '0, lat);
        rd(la(5, 5), 1'b1, 8'h10, dn);
        rd(la(1, 5), 1'b0, '0, '0);
        rd(la(9, 5), 1'b1, 8'h01, d5[9]);

        // T4: read of way 3 protects it; NRU picks way 0 then way 1
        for (int t = 1; t <= 10; t++) d6[t] = rand_line();
        for (int t = 1; t <= 8; t++) fill(la(t, 6), d6[t], 1'b0, '0, lat);
        rd(la(4, 6), 1'b1, 8'h08, d6[4]);
        fill(la(9, 6), d6[9], 1'b1, la(1, 6), lat);
        fill(la(10, 6), d6[10], 1'b1, la(2, 6), lat);
        rd(la(4, 6), 1'b1, 8'h08, d6[4]);
        rd(la(10, 6), 1'b1, 8'h02, d6[10]);

        // T5: invalidate beats a concurrent fill, which is accepted one cycle later
        x7 = rand_line();
        y7 = rand_line();
        fill(la(1, 7), x7, 1'b0, '0, lat);
        bus.fill_en   = 1'b1;
        bus.fill_addr = la(2, 7);
        bus.fill_data = y7;
        bus.inv_en    = 1'b1;
        bus.inv_addr  = la(1, 7);
        tick();
        chk("inv_blocks_fill", 128'(bus.fill_ack), 128'd0);
        tick();
        chk("fill_after_inv", 128'(bus.fill_ack), 128'd1);
        chk("fill_after_inv_expun", 128'(bus.expun_vld), 128'd0);
        bus.fill_en = 1'b0;
        rd(la(1, 7), 1'b0, '0, '0);
        rd(la(2, 7), 1'b1, 8'h01, y7);

        // T6: fill-to-read bypass
        z           = rand_line();
        bus.rd_en   = 1'b1;
        bus.rd_addr = la(3, 80);
        exp_q.push_back({1'b0, 1'b1, 8'h01, z});
        fill(la(3, 80), z, 1'b0, '0, lat);
        rd(la(3, 80), 1'b1, 8'h01, z);

        // T6: reads and fills ignored while busy; reset mid-sweep restarts the sweep
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(la(3, 80), 1'b0, '0, '0);
        bus.fill_en   = 1'b1;
        bus.fill_addr = la(4, 80);
        bus.fill_data = z;
        for (int i = 0; i < 39; i++) begin
            tick();
            chk("busy_no_ack", 128'(bus.fill_ack), 128'd0);
        end
        bus.fill_en = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 128'(bus.init_busy), 128'd1);
        rst = 1'b0;
        count_busy(cnt);
        chk("restart_busy_cycles", 128'(cnt), 128'd128);
        rd(la(3, 80), 1'b0, '0, '0);
        rd(37'h0000123, 1'b0, '0, '0);
        rd(la(9, 5), 1'b0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
